// File: rtl/fft_frame_buffer.sv
// -----------------------------------------------------------------------------
// fft_frame_buffer
//
// Serial-to-parallel framing stage in front of the FFT. Signed samples arrive
// one per cycle on a valid/ready handshake and are collected in a fill bank.
// When the fill bank holds a full frame and the output bank is free, or is
// being consumed in the same cycle, the whole frame is copied into the output
// bank. The output bank is presented on a wide bus with a frame-level
// valid/ready handshake. Because there are two banks, the next frame keeps
// filling while downstream still holds the current one.
//
// Ports
//   clk          system clock; all logic is on the rising edge
//   reset        synchronous, active-high reset
//   in_sample    one signed time-domain sample (passed through bit-exact)
//   in_valid     in_sample is valid this cycle
//   in_ready     block accepts a sample this cycle
//   out_frame    packed frame; sample k at [k*sample_size +: sample_size],
//                k = 0 is the oldest sample
//   frame_valid  out_frame holds a complete frame
//   frame_ready  downstream consumes out_frame this cycle
//   fill_level   number of samples currently held in the fill bank
//
// Parameters
//   sample_size  bits per sample
//   buffer_size  samples per frame; must be a power of two and >= 4
//
// Build option
//   FFT_FRAME_OVERLAP_EN  when defined, consecutive frames overlap by 50 %:
//                         on each transfer the newer half of the fill bank
//                         slides down into the older half and filling resumes
//                         at buffer_size/2. The first frame after reset still
//                         needs a full buffer_size samples.
// -----------------------------------------------------------------------------
module fft_frame_buffer #(
  parameter int sample_size = 32,
  parameter int buffer_size = 32
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [sample_size-1:0]               in_sample,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  output logic [buffer_size*sample_size-1:0]   out_frame,
  output logic                                 frame_valid,
  input  logic                                 frame_ready,
  output logic [$clog2(buffer_size+1)-1:0]     fill_level
);

  localparam int CW = $clog2(buffer_size + 1);
  localparam int IW = $clog2(buffer_size);
  localparam logic [CW-1:0] FULL = CW'(buffer_size);

`ifdef FFT_FRAME_OVERLAP_EN
  localparam int HALF = buffer_size / 2;
  localparam logic [CW-1:0] RESTART = CW'(buffer_size / 2);
`else
  localparam logic [CW-1:0] RESTART = '0;
`endif

  // Frame length must be a power of two (FFT radix-2) and hold at least
  // two samples per half so the overlap mode is meaningful.
  if (buffer_size < 4 || (buffer_size & (buffer_size - 1)) != 0) begin : g_size_check
    $error("fft_frame_buffer: buffer_size must be a power of two and >= 4");
  end

  logic [CW-1:0]          count;
  logic [sample_size-1:0] fill_mem [buffer_size];
  logic [buffer_size*sample_size-1:0] fill_flat;
  logic [IW-1:0]          wr_idx;
  logic                   full;
  logic                   accept;
  logic                   transfer;

  // Handshake decode. in_ready only depends on registered state and reset,
  // never on in_valid, so it is safe for upstream to wait on it.
  assign full     = (count == FULL);
  assign in_ready = !reset && (count < FULL);
  assign accept   = in_valid && in_ready;
  assign transfer = full && (!frame_valid || frame_ready);

  // Whenever a sample is written, count < buffer_size, so the low bits are
  // a valid slot index.
  assign wr_idx = count[IW-1:0];

  assign fill_level = count;

  for (genvar k = 0; k < buffer_size; k++) begin : g_pack
    assign fill_flat[k*sample_size +: sample_size] = fill_mem[k];
  end

  // Fill count. accept and transfer can never coincide: a transfer needs a
  // full bank, and a full bank deasserts in_ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (transfer) begin
      count <= RESTART;
    end else if (accept) begin
      count <= count + CW'(1);
    end
  end

  // Fill bank storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < buffer_size; k++) begin
        fill_mem[k] <= '0;
      end
    end else if (accept) begin
      fill_mem[wr_idx] <= in_sample;
    end
`ifdef FFT_FRAME_OVERLAP_EN
    else if (transfer) begin
      // Newer half becomes the older half of the next frame; the upper half
      // keeps stale data until it is overwritten by new samples.
      for (int k = 0; k < HALF; k++) begin
        fill_mem[k] <= fill_mem[k + HALF];
      end
    end
`endif
  end

  // Output bank and frame handshake. A consume and a transfer in the same
  // cycle leave frame_valid high with the new frame (no gap). A consume
  // alone drops frame_valid but leaves the stale frame on the bus.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_frame   <= '0;
      frame_valid <= 1'b0;
    end else if (transfer) begin
      out_frame   <= fill_flat;
      frame_valid <= 1'b1;
    end else if (frame_ready) begin
      frame_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft_frame_buffer.sv
`timescale 1ns/1ps
module tb_fft_frame_buffer;

  localparam int SS = 32;
  localparam int BS = 32;
  localparam int FW = SS * BS;
  localparam int LW = $clog2(BS + 1);

  typedef logic [FW-1:0] frame_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [SS-1:0] in_sample = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  frame_t        out_frame;
  logic          frame_valid;
  logic          frame_ready = 1'b0;
  logic [LW-1:0] fill_level;

  int total = 0;
  int bad = 0;

  frame_t exp_q[$];

  always #5 clk = ~clk;

  fft_frame_buffer #(.sample_size(SS), .buffer_size(BS)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_sample  (in_sample),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_frame  (out_frame),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .fill_level (fill_level)
  );

  function automatic frame_t mk_frame(input logic [SS-1:0] first);
    frame_t f;
    f = '0;
    for (int k = 0; k < BS; k++) f[k*SS +: SS] = first + SS'(k);
    return f;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic check_frame(input string name, input frame_t act, input frame_t req);
    int bslot;
    bslot = -1;
    total++;
    for (int k = BS - 1; k >= 0; k--)
      if (act[k*SS +: SS] !== req[k*SS +: SS]) bslot = k;
    if (bslot >= 0) begin
      bad++;
      $display("FAIL %s slot=%0d actual=%h required=%h", name, bslot,
               act[bslot*SS +: SS], req[bslot*SS +: SS]);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, report in_ready as
  // seen for the coming rising edge, return at the next falling edge.
  task automatic step(input logic rst, input logic v, input logic [SS-1:0] d,
                      input logic fr, output logic rdy);
    reset       = rst;
    in_valid    = v;
    in_sample   = d;
    frame_ready = fr;
    #1 rdy = in_ready;
    @(negedge clk);
  endtask

  task automatic send_stream(input logic [SS-1:0] first, input int n, input logic fr,
                             output int cycles, output int stalls);
    logic [SS-1:0] d;
    logic r;
    int sent;
    d = first;
    sent = 0;
    cycles = 0;
    stalls = 0;
    while (sent < n && cycles < 500) begin
      step(1'b0, 1'b1, d, fr, r);
      cycles++;
      if (r) begin
        sent++;
        d++;
      end else begin
        stalls++;
      end
    end
    check("stream_sent", sent, n);
  endtask

  // Scoreboard monitor: a frame is consumed whenever frame_valid and
  // frame_ready are both high ahead of a rising edge outside reset.
  initial begin : monitor
    frame_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!reset && frame_valid && frame_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL frame_unexpected actual=%h required=none", out_frame[SS-1:0]);
        end else begin
          e = exp_q.pop_front();
          check_frame("frame", out_frame, e);
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic r;
    int cyc, st, acc;
    logic [SS-1:0] d;
    logic v, fr, prev_fv;
    int sent, ntx;

    @(negedge clk);

    // Reset state
    step(1'b1, 1'b0, '0, 1'b1, r);
    check("rst_in_ready", r, 0);
    check("rst_frame_valid", frame_valid, 0);
    check("rst_fill_level", fill_level, 0);
    check_frame("rst_out_frame", out_frame, '0);

`ifndef FFT_FRAME_OVERLAP_EN
    // Test 1: continuous stream 1..32
    exp_q.push_back(mk_frame(32'd1));
    send_stream(32'd1, 32, 1'b1, cyc, st);
    check("t1_cycles", cyc, 32);
    check("t1_stalls", st, 0);
    check("t1_fv_at_n", frame_valid, 0);
    check("t1_fill_full", fill_level, 32);
    step(1'b0, 1'b0, '0, 1'b1, r);
    check("t1_bubble", r, 0);
    check("t1_fv_at_n1", frame_valid, 1);
    check("t1_fill_zero", fill_level, 0);
    check_frame("t1_out_frame", out_frame, mk_frame(32'd1));
    step(1'b0, 1'b0, '0, 1'b1, r);
    check("t1_ready_back", r, 1);
    check("t1_fv_consumed", frame_valid, 0);

    // Test 2: backpressure on the output bank
    exp_q.push_back(mk_frame(32'd101));
    exp_q.push_back(mk_frame(32'd133));
    send_stream(32'd101, 32, 1'b0, cyc, st);
    step(1'b0, 1'b0, '0, 1'b0, r);
    check("t2_fv_held", frame_valid, 1);
    d = 32'd133;
    acc = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'b1, d, 1'b0, r);
      if (r) begin
        acc++;
        d++;
      end
    end
    check("t2_accepted", acc, 32);
    check("t2_in_ready", in_ready, 0);
    check("t2_fill_level", fill_level, 32);
    check("t2_fv_still", frame_valid, 1);
    check_frame("t2_out_stable", out_frame, mk_frame(32'd101));
    step(1'b0, 1'b0, '0, 1'b1, r);
    check("t2_fv_b2b", frame_valid, 1);
    check("t2_fill_after", fill_level, 0);
    check_frame("t2_new_frame", out_frame, mk_frame(32'd133));
    step(1'b0, 1'b0, '0, 1'b1, r);
    check("t2_fv_drop", frame_valid, 0);

    // Test 3: random gaps and backpressure across the signed wrap point
    for (int f = 0; f < 32; f++) exp_q.push_back(mk_frame(32'h7FFF_FE00 + 32'(f * 32)));
    d = 32'h7FFF_FE00;
    sent = 0;
    cyc = 0;
    while (sent < 1024 && cyc < 20000) begin
      v  = 1'($urandom_range(0, 1));
      fr = 1'($urandom_range(0, 1));
      step(1'b0, v, v ? d : $urandom(), fr, r);
      cyc++;
      if (v && r) begin
        sent++;
        d++;
      end
    end
    check("t3_sent", sent, 1024);
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 200) begin
      step(1'b0, 1'b0, '0, 1'b1, r);
      cyc++;
    end
    check("t3_drained", exp_q.size(), 0);

    // Test 4: reset in the middle of a frame
    send_stream(32'd201, 17, 1'b1, cyc, st);
    check("t4_fill_17", fill_level, 17);
    step(1'b1, 1'b1, 32'd999, 1'b1, r);
    check("t4_rst_ready", r, 0);
    check("t4_fv", frame_valid, 0);
    check("t4_fill", fill_level, 0);
    check_frame("t4_out_zero", out_frame, '0);
    exp_q.push_back(mk_frame(32'd301));
    send_stream(32'd301, 32, 1'b1, cyc, st);
    check("t4_cycles", cyc, 32);
    step(1'b0, 1'b0, '0, 1'b1, r);
    step(1'b0, 1'b0, '0, 1'b1, r);
    check("t4_drained", exp_q.size(), 0);
`else
    // Test 5: 50 % overlap, stream 1..64
    exp_q.push_back(mk_frame(32'd1));
    exp_q.push_back(mk_frame(32'd17));
    exp_q.push_back(mk_frame(32'd33));
    d = 32'd1;
    sent = 0;
    ntx = 0;
    prev_fv = 1'b0;
    for (int i = 0; i < 90; i++) begin
      v = (sent < 64);
      step(1'b0, v, d, 1'b1, r);
      if (v && r) begin
        sent++;
        d++;
      end
      if (frame_valid && !prev_fv) begin
        ntx++;
        check("t5_fill_after_tx", fill_level, 16);
      end
      prev_fv = frame_valid;
    end
    check("t5_sent", sent, 64);
    check("t5_transfers", ntx, 3);
    check("t5_drained", exp_q.size(), 0);
`endif

    check("final_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
